// File: rtl/demux_nbits_deser_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: counter width helper
// and the two-state collection FSM encoding.
package demux_nbits_deser_pkg;

    // Width of the bit-position counter; never narrower than one bit.
    function automatic int cw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

endpackage

// File: rtl/demux_nbits_deser_bit_wr.sv
// One-hot write-enable decoder: routes a single serial bit to word position sel.
// This is the structural inverse of the N:1 bit-select mux on the transmit side.
module demux_bit_wr #(
    parameter int N  = 5,
    parameter int CW = 3
) (
    input  logic [CW-1:0] sel,
    input  logic          wr_en,
    output logic [N-1:0]  en
);

    // Compare against every legal position so a non-power-of-two N never indexes out of range.
    always_comb begin
        en = '0;
        for (int i = 0; i < N; i++) begin
            en[i] = wr_en && (sel == CW'(i));
        end
    end

endmodule

// File: rtl/demux_nbits_deser.sv
// Double-buffered deserializer: collects N serial bits into col while a completed
// word waits in out_word, stalling the serial side only when both are occupied.
module demux_nbits_deser
    import demux_nbits_deser_pkg::*;
#(
    parameter int N = 5,
    localparam int CW = cw_of(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_bit,
    input  logic          in_first,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_word,
    output logic [CW-1:0] bit_pos,
    output logic          sync_err,
    input  logic          err_clr
);

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  col;
    logic [N-1:0]  word_next;
    logic [N-1:0]  wr_en;
    logic [CW-1:0] wr_sel;
    logic          take_in;
    logic          drain;
    logic          last_bit;
    logic          complete;
    logic          slot_free;

    assign take_in   = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign last_bit  = (bit_pos == CW'(N - 1)) && !in_first;
    assign complete  = take_in && last_bit;
    assign slot_free = !out_valid || out_ready;
    assign wr_sel    = in_first ? '0 : bit_pos;

    demux_bit_wr #(
        .N  (N),
        .CW (CW)
    ) u_bit_wr (
        .sel   (wr_sel),
        .wr_en (take_in),
        .en    (wr_en)
    );

    // A resync bit starts a fresh word, so stale partial bits are zeroed rather than kept.
    always_comb begin
        word_next = '0;
        for (int i = 0; i < N; i++) begin
            word_next[i] = wr_en[i] ? in_bit : (in_first ? 1'b0 : col[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (complete && !slot_free) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // In FULL out_valid is already high, so a drain swaps in the pending word without a gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            bit_pos   <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (take_in) begin
                col     <= word_next;
                bit_pos <= in_first ? CW'(1) : (last_bit ? '0 : bit_pos + CW'(1));
            end
            if (state == FULL) begin
                if (out_ready) begin
                    out_word <= col;
                end
            end else if (complete && slot_free) begin
                out_word  <= word_next;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else if (take_in && in_first && (bit_pos != '0)) begin
            sync_err <= 1'b1;
        end else if (err_clr) begin
            sync_err <= 1'b0;
        end
    end

endmodule
